sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//   Shares the single 64Kx8 async SRAM between the Amiga clock-port side (CP) and the Raspberry Pi side (PI).
//   Each side owns a private 16-bit auto-incrementing address pointer. Each side issues register-style
//   requests over a four-phase REQ/ACK handshake. The block round-robins on contention and sequences
//   RAM_A, RAM_OE_n and RAM_WE_n with parameterised setup, strobe and hold timing.
//   It sits between the clock-port/Pi front ends (already synchronised REQ levels) and the SRAM pins.
// PARAMETERS
//   SETUP_CYC  1  cycles of address (+ write data) stable before strobe, >=1
//   WE_CYC     2  RAM_WE_n low width in cycles, >=1
//   RD_CYC     3  RAM_OE_n low width in cycles; RAM_D_IN sampled on last cycle, >=1
//   HOLD_CYC   1  cycles after strobe release with address/data held, >=1
// PORTS
//   CLK         in   1   system clock (100 MHz)
//   RST         in   1   synchronous active-high reset
//   CP_REQ      in   1   clock-port request level (synchronised)
//   CP_WR       in   1   1=write, 0=read; valid while CP_REQ=1
//   CP_A        in   2   register: 0=SRAM data, 1=reserved, 2=ptr lo, 3=ptr hi
//   CP_WDATA    in   8   write data, valid while CP_REQ=1
//   CP_RDATA    out  8   read data, valid while CP_ACK=1
//   CP_ACK      out  1   transaction complete
//   PI_REQ/PI_WR/PI_A/PI_WDATA/PI_RDATA/PI_ACK   same as CP_* for the Pi side
//   RAM_A       out  16  SRAM address
//   RAM_D_OUT   out  8   SRAM write data
//   RAM_D_OE    out  1   1=drive RAM_D_OUT onto the SRAM data bus
//   RAM_D_IN    in   8   SRAM read data
//   RAM_OE_n    out  1   SRAM output enable, active low
//   RAM_WE_n    out  1   SRAM write enable, active low
//   GRANT_PI    out  1   1=current/last owner is the PI side
// BEHAVIOUR
//   Reset: RAM_OE_n=RAM_WE_n=1, RAM_D_OE=0, CP_ACK=PI_ACK=0, RDATA=0, RAM_A=0, both pointers=0,
//     FSM=IDLE, GRANT_PI=1 (so CP wins the first tie). Reset asserted mid-transaction aborts it; strobes are high the next cycle.
//   Pending(side) = REQ && !ACK. ACK rises in DONE and stays high until REQ is sampled low; ACK clears the following cycle.
//   IDLE arbitration: one side pending -> grant it. Both pending -> grant the side with !GRANT_PI (round-robin).
//     A grant captures WR, A and WDATA into registers and updates GRANT_PI.
//   FSM: IDLE -> (A=0) SETUP -> STROBE -> HOLD -> DONE -> IDLE.
//   FSM: IDLE -> (A!=0) DONE -> IDLE.
//   SETUP: RAM_A=granted pointer. On a write, RAM_D_OUT=WDATA and RAM_D_OE=1. Lasts SETUP_CYC cycles.
//   STROBE: write holds RAM_WE_n=0 for WE_CYC cycles. Read holds RAM_OE_n=0 for RD_CYC cycles; RDATA<=RAM_D_IN on the last cycle.
//   HOLD: strobes high, RAM_A and RAM_D_OE unchanged, HOLD_CYC cycles.
//   DONE: RAM_D_OE=0 and granted ACK=1. On A=0 the granted pointer increments by 1, wrapping 16'hFFFF->16'h0000.
//   A=2/3 write: load pointer[7:0]/[15:8] in DONE. A=2/3 read: RDATA=pointer byte. A=1: write ignored, read RDATA=0.
//   RAM_OE_n and RAM_WE_n are never low together, and never low outside STROBE.
//   Latency: SRAM access is grant cycle + SETUP_CYC + strobe + HOLD_CYC + 1; register access is grant cycle + 1.
//     Latency is measured from the first cycle REQ=1 in IDLE to ACK=1.
//   REQ dropped before ACK: the transaction completes, ACK pulses for one cycle, then clears.
//   Between transactions ACK low and REQ high is a new request.
//   Busy-side requests wait; the losing side is served immediately after the current DONE.
// TESTING
//   Reset: RST=1 for 2 cycles -> strobes high, ACKs 0, pointers 0, GRANT_PI=1, RAM_D_OE=0.
//   CP write A=3 0x12, A=2 0x34, then A=0 0xAB -> RAM_WE_n low 2 cycles at RAM_A=0x1234;
//     CP pointer becomes 0x1235; read-back of A=2 returns 0x35.
//   PI ptr=0xFFFF, read A=0 with RAM_D_IN=0x5A -> PI_RDATA=0x5A; ACK at cycle 1+1+3+1+1=7; PI ptr wraps to 0x0000.
//   CP_REQ and PI_REQ rise in the same cycle after reset -> CP served first, then PI.
//     Both re-request -> PI served first, then CP (alternation).
//   Pointers independent: CP ptr=0x0100, PI ptr=0x0200, interleaved writes -> RAM_A alternates 0x0100/0x0200, each +1.
//   RST asserted during STROBE of a write -> RAM_WE_n=1 next cycle, no ACK, pointer=0, next request served normally.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for a 64Kx8 async SRAM: clock-port and Pi sides each own
// an auto-incrementing pointer and talk over a four-phase REQ/ACK handshake.
module sram_port_arbiter #(
    parameter int SETUP_CYC = 1,
    parameter int WE_CYC    = 2,
    parameter int RD_CYC    = 3,
    parameter int HOLD_CYC  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CP_REQ,
    input  logic        CP_WR,
    input  logic [1:0]  CP_A,
    input  logic [7:0]  CP_WDATA,
    output logic [7:0]  CP_RDATA,
    output logic        CP_ACK,
    input  logic        PI_REQ,
    input  logic        PI_WR,
    input  logic [1:0]  PI_A,
    input  logic [7:0]  PI_WDATA,
    output logic [7:0]  PI_RDATA,
    output logic        PI_ACK,
    output logic [15:0] RAM_A,
    output logic [7:0]  RAM_D_OUT,
    output logic        RAM_D_OE,
    input  logic [7:0]  RAM_D_IN,
    output logic        RAM_OE_n,
    output logic        RAM_WE_n,
    output logic        GRANT_PI
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [15:0] cp_ptr;
    logic [15:0] pi_ptr;
    logic        g_wr;
    logic [1:0]  g_a;
    logic [7:0]  g_wdata;

    logic        cp_pend;
    logic        pi_pend;
    logic        pick_pi;
    logic        sel_wr;
    logic [1:0]  sel_a;
    logic [7:0]  sel_wdata;
    logic [15:0] sel_ptr;
    logic [7:0]  reg_rdata;
    logic [7:0]  strobe_last;
    logic [15:0] own_ptr;
    logic [15:0] nxt_ptr;

    assign cp_pend   = CP_REQ && !CP_ACK;
    assign pi_pend   = PI_REQ && !PI_ACK;
    // Tie goes to whichever side did not own the last transaction.
    assign pick_pi   = pi_pend && (!cp_pend || !GRANT_PI);
    assign sel_wr    = pick_pi ? PI_WR : CP_WR;
    assign sel_a     = pick_pi ? PI_A : CP_A;
    assign sel_wdata = pick_pi ? PI_WDATA : CP_WDATA;
    assign sel_ptr   = pick_pi ? pi_ptr : cp_ptr;
    assign own_ptr   = GRANT_PI ? pi_ptr : cp_ptr;

    assign strobe_last = g_wr ? 8'(WE_CYC - 1)
                              : 8'(RD_CYC - 1);

    always_comb begin
        reg_rdata = 8'h00;
        unique case (1'b1)
            sel_a == 2'd2: reg_rdata = sel_ptr[7:0];
            sel_a == 2'd3: reg_rdata = sel_ptr[15:8];
            default:       reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        nxt_ptr = own_ptr;
        unique case (1'b1)
            g_a == 2'd0:
                nxt_ptr = own_ptr + 16'd1;
            g_wr && g_a == 2'd2:
                nxt_ptr = {own_ptr[15:8], g_wdata};
            g_wr && g_a == 2'd3:
                nxt_ptr = {g_wdata, own_ptr[7:0]};
            default:
                nxt_ptr = own_ptr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cp_ptr    <= '0;
            pi_ptr    <= '0;
            g_wr      <= 1'b0;
            g_a       <= '0;
            g_wdata   <= '0;
            RAM_A     <= '0;
            RAM_D_OUT <= '0;
            RAM_D_OE  <= 1'b0;
            RAM_OE_n  <= 1'b1;
            RAM_WE_n  <= 1'b1;
            CP_ACK    <= 1'b0;
            PI_ACK    <= 1'b0;
            CP_RDATA  <= '0;
            PI_RDATA  <= '0;
            GRANT_PI  <= 1'b1;
        end else begin
            // Release runs first so a same-cycle completion still pulses ACK.
            if (!CP_REQ) CP_ACK <= 1'b0;
            if (!PI_REQ) PI_ACK <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cp_pend || pi_pend) begin
                        GRANT_PI <= pick_pi;
                        g_wr     <= sel_wr;
                        g_a      <= sel_a;
                        g_wdata  <= sel_wdata;
                        cnt      <= '0;
                        if (sel_a == 2'd0) begin
                            state    <= S_SETUP;
                            RAM_A    <= sel_ptr;
                            RAM_D_OE <= sel_wr;
                            if (sel_wr) RAM_D_OUT <= sel_wdata;
                        end else begin
                            state <= S_DONE;
                            if (pick_pi) PI_ACK <= 1'b1;
                            else         CP_ACK <= 1'b1;
                            if (!sel_wr) begin
                                if (pick_pi) PI_RDATA <= reg_rdata;
                                else         CP_RDATA <= reg_rdata;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'(SETUP_CYC - 1)) begin
                        cnt      <= '0;
                        state    <= S_STROBE;
                        RAM_WE_n <= !g_wr;
                        RAM_OE_n <= g_wr;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt == strobe_last) begin
                        cnt      <= '0;
                        state    <= S_HOLD;
                        RAM_WE_n <= 1'b1;
                        RAM_OE_n <= 1'b1;
                        if (!g_wr) begin
                            if (GRANT_PI) PI_RDATA <= RAM_D_IN;
                            else          CP_RDATA <= RAM_D_IN;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 8'(HOLD_CYC - 1)) begin
                        cnt      <= '0;
                        state    <= S_DONE;
                        RAM_D_OE <= 1'b0;
                        if (GRANT_PI) PI_ACK <= 1'b1;
                        else          CP_ACK <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (GRANT_PI) pi_ptr <= nxt_ptr;
                    else          cp_ptr <= nxt_ptr;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised scoreboard bench for sram_port_arbiter with an SRAM model and
// a per-side reference of pointers and memory contents.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
    localparam int SETUP = 1;
    localparam int WEC   = 2;
    localparam int RDC   = 3;
    localparam int HOLD  = 1;
    localparam int L_REG = 2;
    localparam int L_WR  = 1 + SETUP + WEC + HOLD + 1;
    localparam int L_RD  = 1 + SETUP + RDC + HOLD + 1;

    typedef struct {
        bit         chk;
        logic [7:0] rd;
        int         lat;
    } exp_t;

    typedef struct {
        bit          w;
        logic [15:0] ad;
        logic [7:0]  d;
    } acc_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [1:0]      req = '0;
    logic [1:0]      wr = '0;
    logic [1:0][1:0] a = '0;
    logic [1:0][7:0] wdata = '0;
    wire  [1:0]      ack;
    wire  [1:0][7:0] rdata;
    wire  [15:0]     ram_a;
    wire  [7:0]      ram_d_out;
    wire  [7:0]      ram_d_in;
    wire             ram_d_oe;
    wire             ram_oe_n;
    wire             ram_we_n;
    wire             grant_pi;

    logic [7:0]  sram [65536];
    logic [7:0]  ref_mem [65536];
    logic [15:0] ptr [2];
    int          issue_cyc [2];
    exp_t        eq0[$];
    exp_t        eq1[$];
    acc_t        aq0[$];
    acc_t        aq1[$];

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    sram_port_arbiter #(
        .SETUP_CYC(SETUP), .WE_CYC(WEC),
        .RD_CYC(RDC), .HOLD_CYC(HOLD)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CP_REQ(req[0]), .CP_WR(wr[0]), .CP_A(a[0]),
        .CP_WDATA(wdata[0]), .CP_RDATA(rdata[0]),
        .CP_ACK(ack[0]),
        .PI_REQ(req[1]), .PI_WR(wr[1]), .PI_A(a[1]),
        .PI_WDATA(wdata[1]), .PI_RDATA(rdata[1]),
        .PI_ACK(ack[1]),
        .RAM_A(ram_a), .RAM_D_OUT(ram_d_out),
        .RAM_D_OE(ram_d_oe), .RAM_D_IN(ram_d_in),
        .RAM_OE_n(ram_oe_n), .RAM_WE_n(ram_we_n),
        .GRANT_PI(grant_pi)
    );

    assign ram_d_in = sram[ram_a];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check(input string name,
                                  input int got,
                                  input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)",
                      name, got, exp, $time);
    endfunction

    // Reference: per-side pointer plus memory image, at register level.
    function automatic void model(input int s, input bit w,
                                  input logic [1:0] aa,
                                  input logic [7:0] d,
                                  input int lat);
        exp_t e;
        acc_t x;
        e.chk = !w;
        e.rd  = 8'h00;
        e.lat = lat;
        case (aa)
            2'd0: begin
                x.w = w; x.ad = ptr[s]; x.d = d;
                if (w) ref_mem[ptr[s]] = d;
                else   e.rd = ref_mem[ptr[s]];
                if (s == 0) aq0.push_back(x);
                else        aq1.push_back(x);
                ptr[s] = ptr[s] + 16'd1;
            end
            2'd1: e.rd = 8'h00;
            2'd2: if (w) ptr[s][7:0] = d;
                  else   e.rd = ptr[s][7:0];
            default: if (w) ptr[s][15:8] = d;
                     else   e.rd = ptr[s][15:8];
        endcase
        if (s == 0) eq0.push_back(e);
        else        eq1.push_back(e);
    endfunction

    task automatic txn(input int s, input bit w,
                       input logic [1:0] aa, input logic [7:0] d,
                       input int lat, input int hold,
                       input bit early);
        bit got;
        got = 1'b0;
        @(posedge CLK); #1;
        req[s] = 1'b1; wr[s] = w; a[s] = aa; wdata[s] = d;
        issue_cyc[s] = cyc;
        model(s, w, aa, d, lat);
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge CLK); #1;
            if (early) req[s] = 1'b0;
            got = ack[s];
        end
        if (!got) begin
            checks++;
            $display("FAIL ack_timeout side %0d: ACK=0 after 200 cycles, required 1", s);
            req[s] = 1'b0;
        end else if (early) begin
            @(posedge CLK); #1;
            check("ack_pulse", ack[s], 0);
        end else begin
            repeat (hold) begin
                @(posedge CLK); #1;
                check("ack_hold", ack[s], 1);
            end
            req[s] = 1'b0;
            @(posedge CLK); #1;
            check("ack_release", ack[s], 0);
        end
    endtask

    task automatic rand_side(input int s, input int n);
        bit w;
        int r;
        logic [1:0] aa;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            w  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            aa = (r < 6) ? 2'd0 : (r == 6) ? 2'd1
               : (r == 7) ? 2'd2 : 2'd3;
            d  = 8'($urandom);
            // Keep each side inside its own address half.
            if (aa == 2'd3)
                d = (s == 0) ? 8'(8'h10 + $urandom_range(0, 47))
                             : 8'(8'h90 + $urandom_range(0, 47));
            txn(s, w, aa, d, -1, $urandom_range(0, 2), 1'b0);
        end
    endtask

    logic [1:0] ack_q = '0;
    logic we_q = 1'b1;
    logic oe_q = 1'b1;
    bit   was_we = 1'b0;
    int   run = 0;
    int   sz;
    exp_t me;
    acc_t mx;

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (ack[i] && !ack_q[i]) begin
                sz = (i == 0) ? eq0.size() : eq1.size();
                check("ack_expected", int'(sz > 0), 1);
                if (sz > 0) begin
                    if (i == 0) me = eq0.pop_front();
                    else        me = eq1.pop_front();
                    if (me.chk) check("rdata", rdata[i], me.rd);
                    if (me.lat >= 0)
                        check("latency", cyc - issue_cyc[i] + 1,
                              me.lat);
                end
            end
        end
        if (!ram_oe_n || !ram_we_n)
            check("strobe_exclusive",
                  int'(!ram_oe_n && !ram_we_n), 0);
        if ((!ram_we_n && we_q) || (!ram_oe_n && oe_q)) begin
            was_we = !ram_we_n;
            run = 0;
            sz = grant_pi ? aq1.size() : aq0.size();
            check("access_expected", int'(sz > 0), 1);
            if (sz > 0) begin
                if (grant_pi) mx = aq1.pop_front();
                else          mx = aq0.pop_front();
                check("ram_a", ram_a, mx.ad);
                check("access_dir", was_we, mx.w);
                if (mx.w) check("ram_d_out", ram_d_out, mx.d);
            end
        end
        if (!ram_we_n) begin
            check("ram_d_oe_write", ram_d_oe, 1);
            sram[ram_a] = ram_d_out;
        end
        if (!ram_oe_n) check("ram_d_oe_read", ram_d_oe, 0);
        if (!ram_oe_n || !ram_we_n) run++;
        else if ((!we_q || !oe_q) && !RST)
            check("strobe_width", run, was_we ? WEC : RDC);
        we_q  = ram_we_n;
        oe_q  = ram_oe_n;
        ack_q = ack;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 8'(i ^ (i >> 8));
            ref_mem[i] = sram[i];
        end
        sram[16'hFFFF]    = 8'h5A;
        ref_mem[16'hFFFF] = 8'h5A;
        ptr[0] = '0;
        ptr[1] = '0;

        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_oe_n", ram_oe_n, 1);
        check("rst_we_n", ram_we_n, 1);
        check("rst_acks", ack, 0);
        check("rst_grant_pi", grant_pi, 1);
        check("rst_d_oe", ram_d_oe, 0);
        check("rst_ram_a", ram_a, 0);
        check("rst_rdata", rdata, 0);
        RST = 1'b0;

        txn(1, 0, 2'd2, 8'h00, L_REG, 0, 0);
        txn(0, 0, 2'd3, 8'h00, L_REG, 0, 0);

        txn(0, 1, 2'd3, 8'h12, L_REG, 0, 0);
        txn(0, 1, 2'd2, 8'h34, L_REG, 0, 0);
        txn(0, 1, 2'd0, 8'hAB, L_WR, 1, 0);
        txn(0, 0, 2'd2, 8'h00, L_REG, 0, 0);
        txn(0, 0, 2'd3, 8'h00, L_REG, 2, 0);
        txn(0, 0, 2'd1, 8'h00, L_REG, 0, 0);
        txn(0, 1, 2'd1, 8'hEE, L_REG, 0, 0);
        txn(0, 1, 2'd2, 8'h34, L_REG, 0, 0);
        txn(0, 0, 2'd0, 8'h00, L_RD, 0, 0);

        txn(1, 1, 2'd3, 8'hFF, L_REG, 0, 0);
        txn(1, 1, 2'd2, 8'hFF, L_REG, 0, 0);
        txn(1, 0, 2'd0, 8'h00, L_RD, 0, 0);
        txn(1, 0, 2'd2, 8'h00, L_REG, 0, 0);
        txn(1, 0, 2'd3, 8'h00, L_REG, 0, 0);
        txn(1, 1, 2'd2, 8'h55, L_REG, 0, 0);
        txn(1, 0, 2'd0, 8'h00, L_RD, 0, 1);

        fork
            txn(0, 0, 2'd2, 8'h00, L_REG, 0, 0);
            txn(1, 0, 2'd2, 8'h00, L_REG + 2, 0, 0);
        join
        txn(0, 0, 2'd3, 8'h00, L_REG, 0, 0);
        fork
            txn(0, 0, 2'd2, 8'h00, L_REG + 2, 0, 0);
            txn(1, 0, 2'd2, 8'h00, L_REG, 0, 0);
        join

        txn(0, 1, 2'd3, 8'h01, L_REG, 0, 0);
        txn(0, 1, 2'd2, 8'h00, L_REG, 0, 0);
        txn(1, 1, 2'd3, 8'h02, L_REG, 0, 0);
        txn(1, 1, 2'd2, 8'h00, L_REG, 0, 0);
        fork
            repeat (3) txn(0, 1, 2'd0, 8'($urandom), -1, 0, 0);
            repeat (3) txn(1, 1, 2'd0, 8'($urandom), -1, 0, 0);
        join
        txn(0, 0, 2'd2, 8'h00, L_REG, 0, 0);
        txn(1, 0, 2'd2, 8'h00, L_REG, 0, 0);

        txn(0, 1, 2'd3, 8'h70, L_REG, 0, 0);
        txn(0, 1, 2'd2, 8'h00, L_REG, 0, 0);
        @(posedge CLK); #1;
        req[0] = 1'b1; wr[0] = 1'b1; a[0] = 2'd0;
        wdata[0] = 8'hC3;
        aq0.push_back('{1'b1, 16'h7000, 8'hC3});
        ref_mem[16'h7000] = 8'hC3;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge CLK);
            seen = !ram_we_n;
        end
        check("abort_strobe_seen", seen, 1);
        RST = 1'b1;
        req[0] = 1'b0;
        @(posedge CLK); #1;
        check("abort_we_high", ram_we_n, 1);
        check("abort_oe_high", ram_oe_n, 1);
        check("abort_no_ack", ack, 0);
        check("abort_d_oe", ram_d_oe, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        ptr[0] = '0;
        ptr[1] = '0;
        repeat (3) begin
            @(posedge CLK); #1;
            check("abort_ack_low", ack, 0);
        end
        txn(0, 0, 2'd2, 8'h00, L_REG, 0, 0);
        txn(0, 0, 2'd3, 8'h00, L_REG, 0, 0);
        txn(1, 0, 2'd3, 8'h00, L_REG, 0, 0);
        txn(0, 1, 2'd0, 8'h77, L_WR, 0, 0);

        txn(0, 1, 2'd3, 8'(8'h10 + $urandom_range(0, 31)), L_REG, 0, 0);
        txn(0, 1, 2'd2, 8'($urandom), L_REG, 0, 0);
        txn(1, 1, 2'd3, 8'(8'h90 + $urandom_range(0, 31)), L_REG, 0, 0);
        txn(1, 1, 2'd2, 8'($urandom), L_REG, 0, 0);
        fork
            rand_side(0, 40);
            rand_side(1, 40);
        join

        repeat (5) @(posedge CLK);
        #1;
        check("scoreboard_drain",
              eq0.size() + eq1.size() + aq0.size() + aq1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
